// File: rtl/addsub_serial.sv
// addsub_serial: bit-serial two's-complement adder/subtractor.
// Operands are captured in parallel on an accepted start, then one bit per
// cycle is pushed LSB-first through a single full-adder slice. After WIDTH
// RUN cycles the unit spends one cycle in DONE with done=1, sum final and
// ovfl = carry-into-MSB XOR carry-out-of-MSB.
// Optional build macro: ADDSUB_SERIAL_SATURATE_EN clamps an overflowed
// result to the most-positive / most-negative value, chosen by the sign of A.
module addsub_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             ovfl
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             w_accept;
   logic             w_last;

   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_c_in_msb;
   logic             r_c_out;

   logic             w_bit_a;
   logic             w_bit_b;
   logic             w_sum_bit;
   logic             w_carry_out;
   logic [WIDTH-1:0] w_sum_shift;
   logic             w_ovfl_final;
   logic [WIDTH-1:0] w_sum_final;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode plus the state-derived outputs and control strobes.
   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == LAST_BIT) begin
               w_last       = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            // A start here is taken exactly as from IDLE (back-to-back).
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = S_RUN;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Single full-adder slice on the operand LSBs, plus the shifted partial sum.
   always_comb begin
      w_bit_a      = r_opa[0];
      w_bit_b      = r_opb[0];
      w_sum_bit    = w_bit_a ^ w_bit_b ^ r_carry;
      w_carry_out  = (w_bit_a & w_bit_b) | (r_carry & (w_bit_a ^ w_bit_b));
      w_sum_shift  = {w_sum_bit, r_sum[WIDTH-1:1]};
      // On the MSB slice r_carry is the carry into the MSB.
      w_ovfl_final = r_carry ^ w_carry_out;
   end

`ifdef ADDSUB_SERIAL_SATURATE_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Clamp on overflow. r_opa is shifted arithmetically, so its MSB is still
   // the captured sign of A when the last bit is processed.
   always_comb begin
      w_sum_final = w_sum_shift;
      if (w_ovfl_final) begin
         w_sum_final = r_opa[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   // Wrapped result: the final value is simply the last shifted sum.
   always_comb begin
      w_sum_final = w_sum_shift;
   end
`endif

   // Operand capture, bit-serial shifting, carry and counter update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa      <= '0;
         r_opb      <= '0;
         r_sum      <= '0;
         r_carry    <= 1'b0;
         r_cnt      <= '0;
         r_c_in_msb <= 1'b0;
         r_c_out    <= 1'b0;
      end else if (w_accept) begin
         // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
         r_opa   <= A;
         r_opb   <= B ^ {WIDTH{sub}};
         r_carry <= sub;
         r_cnt   <= '0;
      end else if (busy) begin
         r_opa   <= {r_opa[WIDTH-1], r_opa[WIDTH-1:1]};
         r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
         r_carry <= w_carry_out;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            r_sum      <= w_sum_final;
            r_c_in_msb <= r_carry;
            r_c_out    <= w_carry_out;
         end else begin
            r_sum <= w_sum_shift;
         end
      end
   end

   assign sum  = r_sum;
   assign ovfl = r_c_in_msb ^ r_c_out;

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed and random checks of addsub_serial (WIDTH=4)
// against an integer-arithmetic reference model.
module tb_addsub_serial;

   localparam int W    = 4;
   localparam int MAXV = (2 ** (W - 1)) - 1;
   localparam int MINV = -(2 ** (W - 1));

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         ovfl;

   int n_vec;
   int n_err;

   addsub_serial #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .ovfl  (ovfl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: signed integer arithmetic, overflow = true result out of range.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] es, output logic eo);
      int sa;
      int sb;
      int full;
      logic [31:0] fv;
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      full = s ? (sa - sb) : (sa + sb);
      eo   = (full > MAXV) || (full < MINV);
      fv   = full;
      es   = fv[W-1:0];
`ifdef ADDSUB_SERIAL_SATURATE_EN
      if (eo) es = (sa < 0) ? W'(MINV) : W'(MAXV);
`endif
   endtask

   // Present an operation now; return #1 after the edge that samples it.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      start = 1'b1;
      A     = a;
      B     = b;
      sub   = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = W'($urandom);
      B     = W'($urandom);
      sub   = 1'($urandom);
   endtask

   // Wait (bounded) for done; report edges waited and busy cycles seen.
   task automatic wait_done(output int n, output int bc);
      n  = 0;
      bc = 0;
      while (!done && n < 50) begin
         if (busy) bc++;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // Full operation: issue, wait, check latency, busy, sum and ovfl.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
      int n;
      int bc;
      logic [W-1:0] es;
      logic eo;
      model(a, b, s, es, eo);
      issue(a, b, s);
      wait_done(n, bc);
      check({tag, "_latency"}, n, W);
      check({tag, "_busy_cycles"}, bc, W);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_sum"}, sum, es);
      check({tag, "_ovfl"}, ovfl, eo);
   endtask

   initial begin
      int n;
      int bc;
      logic [W-1:0] es;
      logic eo;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      sub   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_sum", sum, 4'd0);
      check("reset_ovfl", ovfl, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_no_start", busy, 1'b0);

      run_op("add_3_2", 4'd3, 4'd2, 1'b0);
      // Result holds after DONE returns to IDLE.
      @(posedge clk);
      #1;
      check("hold_done", done, 1'b0);
      check("hold_busy", busy, 1'b0);
      check("hold_sum", sum, 4'd5);
      check("hold_ovfl", ovfl, 1'b0);

      run_op("add_7_1", 4'd7, 4'd1, 1'b0);
      run_op("sub_m8_1", 4'b1000, 4'd1, 1'b0 | 1'b1);
      // Back-to-back: issued during the DONE cycle.
      run_op("b2b_sub_5_3", 4'd5, 4'd3, 1'b1);
      @(posedge clk);
      #1;
      run_op("sub_2_m8", 4'd2, 4'b1000, 1'b1);
      run_op("sub_m3_m8", 4'b1101, 4'b1000, 1'b1);
      run_op("sub_equal", 4'd6, 4'd6, 1'b1);

      // Start re-pulsed during RUN must be ignored.
      @(posedge clk);
      #1;
      model(4'd1, 4'd1, 1'b0, es, eo);
      issue(4'd1, 4'd1, 1'b0);
      issue(4'd6, 4'd6, 1'b0);
      wait_done(n, bc);
      check("ignore_latency", n + 1, W);
      check("ignore_sum", sum, es);
      check("ignore_ovfl", ovfl, eo);

      // Asynchronous reset between edges mid-RUN.
      @(posedge clk);
      #1;
      issue(4'd5, 4'd1, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_sum", sum, 4'd0);
      check("arst_ovfl", ovfl, 1'b0);
      bc = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (done) bc++;
      end
      check("arst_no_done", bc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("post_reset_m1_m1", 4'b1111, 4'b1111, 1'b0);

      // Random operations with random idle gaps (including back-to-back).
      for (int i = 0; i < 100; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
         end
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
